// File: rtl/fir_coeff_sample_ctrl.sv
// Coefficient double-buffer and sample-issue control ahead of the transposed FIR datapath.
// Host writes a shadow bank; a committed bank is swapped into the active bank between samples.
module fir_coeff_sample_ctrl #(
  parameter int NTAPS = 33,
  parameter int CW    = 16,
  parameter int SW    = 3
) (
  input  logic                  iClk_12M,
  input  logic                  iRst,
  input  logic                  iCoeffWrEn,
  input  logic [5:0]            iCoeffAddr,
  input  logic [CW-1:0]         iCoeffData,
  input  logic                  iCoeffCommit,
  input  logic                  iSampleValid,
  input  logic [SW-1:0]         iSampleIn,
  output logic                  oEnAcc,
  output logic [SW-1:0]         oFirIn,
  output logic [NTAPS*CW-1:0]   oCoeff,
  output logic                  oCoeffValid,
  output logic                  oAddrErr,
  output logic                  oCommitErr
);

  typedef enum logic {S_EMPTY, S_RUN} state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [NTAPS*CW-1:0] r_shadow;
  logic [NTAPS*CW-1:0] r_active;
  logic [NTAPS-1:0]    r_mask;
  logic                r_pending;
  logic                r_en_acc;
  logic [SW-1:0]       r_fir_in;
  logic                r_coeff_valid;
  logic                r_addr_err;
  logic                r_commit_err;

  logic                w_addr_ok;
  logic                w_wr_ok;
  logic                w_wr_err;
  logic [NTAPS-1:0]    w_mask_wr;
  logic                w_commit_ok;
  logic                w_commit_err;
  logic                w_issue;
  logic                w_swap;

  // Writes are locked out while a swap is pending so committed data cannot be disturbed.
  assign w_addr_ok    = (iCoeffAddr < 6'(NTAPS));
  assign w_wr_ok      = iCoeffWrEn & w_addr_ok & ~r_pending;
  assign w_wr_err     = iCoeffWrEn & ~(w_addr_ok & ~r_pending);
  assign w_mask_wr    = r_mask | (w_wr_ok ? (NTAPS'(1) << iCoeffAddr) : '0);
  assign w_commit_ok  = iCoeffCommit & ~r_pending & (&w_mask_wr);
  assign w_commit_err = iCoeffCommit & ~r_pending & ~(&w_mask_wr);
  assign w_issue      = iSampleValid & (r_state == S_RUN);
  assign w_swap       = r_pending & ~w_issue;

  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_EMPTY: if (w_swap) w_state_next = S_RUN;
      S_RUN:   w_state_next = S_RUN;
      default: w_state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      r_shadow      <= '0;
      r_active      <= '0;
      r_mask        <= '0;
      r_pending     <= 1'b0;
      r_en_acc      <= 1'b0;
      r_fir_in      <= '0;
      r_coeff_valid <= 1'b0;
      r_addr_err    <= 1'b0;
      r_commit_err  <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_shadow[iCoeffAddr*CW +: CW] <= iCoeffData;
      end
      // Swap and an accepted write never coincide: both depend on r_pending, oppositely.
      if (w_swap) begin
        r_active      <= r_shadow;
        r_mask        <= '0;
        r_pending     <= 1'b0;
        r_coeff_valid <= 1'b1;
      end else begin
        r_mask <= w_mask_wr;
        if (w_commit_ok) begin
          r_pending <= 1'b1;
        end
      end
      r_en_acc <= w_issue;
      if (w_issue) begin
        r_fir_in <= iSampleIn;
      end
      r_addr_err   <= w_wr_err;
      r_commit_err <= w_commit_err;
    end
  end

  assign oEnAcc      = r_en_acc;
  assign oFirIn      = r_fir_in;
  assign oCoeff      = r_active;
  assign oCoeffValid = r_coeff_valid;
  assign oAddrErr    = r_addr_err;
  assign oCommitErr  = r_commit_err;

endmodule
